i2s_rx_fifo: RTL and testbench
==============================

# i2s_rx_fifo

I2S receiver front-end that generates the I2S serial clock and word-select, deserialises the `sd` input into 24-bit left/right samples, and buffers them in a small FIFO. It sits between the external I2S microphone pins and the SoC bus-side register block, which drains samples over a valid/ready stream. The SoC's `i2s_clk`/`ws` outputs are driven by this block.

## Interface
Parameters:
- `CLK_DIV`, 4: HCLK cycles per half SCK period; legal range 1..255.
- `SAMPLE_BITS`, 24: captured bits per channel; legal range 1..31.
- `FIFO_DEPTH`, 8: FIFO entries; must be a power of two and ≥2.

Ports:
- `HCLK` in 1: the block's single clock.
- `HRESETn` in 1: asynchronous, active-low reset.
- `en` in 1: receiver enable.
- `sd` in 1: I2S serial data, already synchronised to HCLK.
- `i2s_clk` out 1: generated SCK.
- `ws` out 1: word select; 0 = left, 1 = right.
- `sample_data` out 32: `{8'h00, sample}`, zero-extended, where `sample` is right-aligned and `SAMPLE_BITS` wide.
- `sample_right` out 1: channel of `sample_data`.
- `sample_valid` out 1: FIFO head is valid.
- `sample_ready` in 1: consumer accepts the head.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: number of occupied entries.
- `overrun` out 1: sticky flag, set when a sample is dropped.
- `overrun_clr` in 1: one-cycle pulse that clears `overrun`.

## Operation
- Reset values: `i2s_clk`=0, `ws`=0, `sample_valid`=0, `sample_data`=0, `sample_right`=0, `fifo_level`=0, `overrun`=0. The divider counter, the 6-bit bit counter, and the shift register are all 0.
- SCK divider:
  - While `en`=1, the divider counter counts 0..`CLK_DIV`-1.
  - At terminal count it wraps to 0 and `i2s_clk` toggles.
- Falling SCK toggle (1→0):
  - The bit counter `bc` increments modulo 64.
  - `ws` is registered from the new `bc[5]`. A frame is 32 left SCKs followed by 32 right SCKs.
- Rising SCK toggle (0→1):
  - `sd` is sampled in the same HCLK edge.
  - Slot `s` = `bc[4:0]` and channel = `bc[5]`.
  - Slot 0 is the standard I2S one-bit delay and is ignored.
  - Slots 1..`SAMPLE_BITS` shift in MSB first, clearing the shift register at slot 1.
  - Slots above `SAMPLE_BITS` are ignored.
- Completion: at the slot-`SAMPLE_BITS` capture, a push request is raised for the next HCLK edge with data `{8'h00, shift}` and channel = `bc[5]`.
- Push rules:
  - If the FIFO is not full, or a pop occurs in the same cycle, the entry is written.
  - Otherwise the sample is dropped and `overrun` is set.
- Pop: occurs when `sample_valid`=1 and `sample_ready`=1.
- FIFO behaviour:
  - First-word-fall-through; `sample_data`/`sample_right` always show the head.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `fifo_level` updates by +1 on push, −1 on pop, and is unchanged on a simultaneous push and pop.
- `overrun_clr` versus a drop in the same cycle: the drop wins and `overrun` stays 1.
- `en` deassert:
  - On the next edge, the divider, `bc`, `i2s_clk`, and `ws` return to 0.
  - Any partial sample is discarded and no push occurs.
  - FIFO contents are retained and remain drainable.
- `en` reassert: the frame restarts at `bc`=0 (left, slot 0). The first falling toggle moves `bc` to 1.
- Asynchronous reset mid-frame: all state returns to reset values immediately and the FIFO is emptied.

## Timing
- SCK period = 2·`CLK_DIV` HCLK cycles; a frame is 128·`CLK_DIV` HCLK cycles.
- `ws` changes on the same HCLK edge as the SCK falling toggle.
- Latency:
  - Last sample bit captured at edge E.
  - FIFO write at edge E+1.
  - With an empty FIFO, `sample_valid`=1 from edge E+1.
- Under no backpressure, the FIFO never exceeds 1 entry; the consumer has 32·SCK between samples.
- A pop at edge P: the next head is visible from P, i.e. in the cycle after P. `sample_valid` drops at P if the FIFO becomes empty.

## Test plan
- Basic frame: `CLK_DIV`=4, `en`=1, left word 0xABCDEFAB and right word 0x55667788 driven MSB first from slot 1 on `sd`, with `sample_ready`=1 → outputs (0x00ABCDEF, right=0) then (0x00556677, right=1). The `i2s_clk` period is 8 HCLK cycles and `ws` toggles every 32 SCKs.
- Clock/WS shape: `CLK_DIV`=1 → `i2s_clk` toggles every HCLK cycle, the first `ws` rise comes 32 SCK periods after enable, and `ws` changes only with a falling toggle.
- Backpressure/overrun:
  - Hold `sample_ready`=0 for 9 half-frames with `FIFO_DEPTH`=8 → `fifo_level`=8, `overrun`=1, and the 9th sample is dropped.
  - Draining then yields the first 8 samples in order.
  - An `overrun_clr` pulse then clears the flag.
- Full with simultaneous pop:
  - FIFO at 8 entries, and `sample_ready` pulsed on the exact push cycle → `fifo_level` stays 8 and `overrun` stays 0.
  - The new sample appears last in the drain order.
- Disable mid-frame: deassert `en` at left slot 10 → no push occurs, `i2s_clk`/`ws`=0 on the next edge, and existing entries still drain. Reenable, then send 0x12345678 → output 0x00123456 with right=0.
- Reset mid-operation: assert `HRESETn`=0 with 3 entries queued and a sample in progress → all outputs immediately return to their reset values. After release, the next full frame is received correctly.

Source files
------------

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: I2S master receiver (SCK/WS generation, sample deserialiser) feeding a FWFT sample FIFO
module i2s_rx_fifo #(
    parameter int CLK_DIV     = 4,
    parameter int SAMPLE_BITS = 24,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          en,
    input  logic                          sd,
    output logic                          i2s_clk,
    output logic                          ws,
    output logic [31:0]                   sample_data,
    output logic                          sample_right,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          overrun_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0]    DIV_TC = 8'(CLK_DIV - 1);
    localparam logic [4:0]    SB     = 5'(SAMPLE_BITS);
    localparam logic [LW-1:0] FULL   = LW'(FIFO_DEPTH);

    logic [7:0]             div_q, div_d;
    logic                   sck_q, sck_d, ws_q, ws_d;
    logic [5:0]             bc_q, bc_d;
    logic [SAMPLE_BITS-1:0] sh_q, sh_d;
    logic                   push_q, push_d, pushr_q, pushr_d;
    logic                   tick, rise, fall, cap;
    logic [4:0]             slot;
    logic [32:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wp_q, rp_q;
    logic [LW-1:0]          lvl_q;
    logic                   ovr_q, pop, wr, drop;

    // Divider, SCK/WS generation and slot-driven capture; disabling collapses the frame back to left slot 0
    always_comb begin
        tick    = en && div_q == DIV_TC;
        rise    = tick && !sck_q;
        fall    = tick && sck_q;
        slot    = bc_q[4:0];
        div_d   = (!en || tick) ? 8'd0 : div_q + 8'd1;
        sck_d   = en && (sck_q ^ tick);
        bc_d    = en ? bc_q + 6'(fall) : 6'd0;
        ws_d    = en && (fall ? bc_d[5] : ws_q);
        cap     = rise && slot != 5'd0 && slot <= SB;
        sh_d    = !cap ? sh_q : slot == 5'd1 ? SAMPLE_BITS'(sd) : SAMPLE_BITS'({sh_q, sd});
        push_d  = cap && slot == SB;
        pushr_d = bc_q[5];
    end

    // A push needs room unless the head leaves in the same cycle; otherwise the sample is lost
    always_comb begin
        pop  = lvl_q != '0 && sample_ready;
        wr   = push_q && (lvl_q != FULL || pop);
        drop = push_q && !wr;
    end

    // Receiver front-end state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            div_q   <= '0;
            sck_q   <= 1'b0;
            ws_q    <= 1'b0;
            bc_q    <= '0;
            sh_q    <= '0;
            push_q  <= 1'b0;
            pushr_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            sck_q   <= sck_d;
            ws_q    <= ws_d;
            bc_q    <= bc_d;
            sh_q    <= sh_d;
            push_q  <= push_d;
            pushr_q <= pushr_d;
        end
    end

    // FIFO storage, pointers, occupancy and sticky overrun (a drop beats a clear)
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (wr) mem_q[wp_q] <= {pushr_q, 32'(sh_q)};
            wp_q  <= wp_q + AW'(wr);
            rp_q  <= rp_q + AW'(pop);
            lvl_q <= lvl_q + LW'(wr) - LW'(pop);
            ovr_q <= drop || (ovr_q && !overrun_clr);
        end
    end

    assign i2s_clk      = sck_q;
    assign ws           = ws_q;
    assign {sample_right, sample_data} = mem_q[rp_q];
    assign sample_valid = lvl_q != '0;
    assign fifo_level   = lvl_q;
    assign overrun      = ovr_q;
endmodule

// File: tb/tb_i2s_rx_fifo.sv
// tb_i2s_rx_fifo: directed/random I2S frames checked against a queue-based reference model
module tb_i2s_rx_fifo;
    localparam int FD = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        en = 1'b0, sd = 1'b0, sample_ready = 1'b0, overrun_clr = 1'b0;
    logic        i2s_clk, ws, sample_right, sample_valid, overrun;
    logic [31:0] sample_data;
    logic [3:0]  fifo_level;

    logic        en1 = 1'b0;
    logic        i2s_clk1, ws1, sample_right1, sample_valid1, overrun1;
    logic [31:0] sample_data1;
    logic [3:0]  fifo_level1;

    int          total = 0, bad = 0;
    int          cyc = 0, c1 = 0;
    logic [31:0] wq [$];
    logic [32:0] mq [$];
    logic [32:0] got [$];
    logic        ovr = 1'b0, pend = 1'b0;
    logic [32:0] pval = '0;

    always #5 HCLK = ~HCLK;

    i2s_rx_fifo #(.CLK_DIV(4), .SAMPLE_BITS(24), .FIFO_DEPTH(FD)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .sd(sd),
        .i2s_clk(i2s_clk), .ws(ws), .sample_data(sample_data), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .fifo_level(fifo_level),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    i2s_rx_fifo #(.CLK_DIV(1), .SAMPLE_BITS(24), .FIFO_DEPTH(FD)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en1), .sd(1'b0),
        .i2s_clk(i2s_clk1), .ws(ws1), .sample_data(sample_data1), .sample_right(sample_right1),
        .sample_valid(sample_valid1), .sample_ready(1'b1), .fifo_level(fifo_level1),
        .overrun(overrun1), .overrun_clr(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill();
        wq.delete();
        repeat (24) wq.push_back($urandom);
    endtask

    // Serial bit on the wire for the SCK period containing enabled edge e (slot 0 carries junk)
    function automatic logic bit_at(int e);
        int k = e / 8;
        int s = k % 32;
        int h = k / 32;
        logic [31:0] w;
        if (s == 0) return 1'($urandom);
        w = wq[h];
        return w[32 - s];
    endfunction

    task automatic step();
        logic        en_b, rdy_b, clr_b, en1_b, drop;
        logic [32:0] head_b;
        int          e, h;
        sd     = en ? bit_at(cyc + 1) : 1'b0;
        en_b   = en;
        rdy_b  = sample_ready;
        clr_b  = overrun_clr;
        en1_b  = en1;
        head_b = {sample_right, sample_data};
        @(posedge HCLK);
        #1;
        if (rdy_b && mq.size() > 0) begin
            chk("pop_head", head_b, mq[0]);
            got.push_back(head_b);
            void'(mq.pop_front());
        end
        drop = 1'b0;
        if (pend) begin
            if (mq.size() < FD) mq.push_back(pval);
            else begin
                drop = 1'b1;
                ovr  = 1'b1;
            end
        end
        if (!drop && clr_b) ovr = 1'b0;
        pend = 1'b0;
        if (en_b) begin
            cyc++;
            e = cyc;
            if (e >= 4 && (e - 4) % 8 == 0 && ((e - 4) / 8) % 32 == 24) begin
                h    = (e - 4) / 256;
                pend = 1'b1;
                pval = {h[0], 8'h00, wq[h][31:8]};
            end
        end
        chk("sck", i2s_clk, en_b ? 1'((cyc / 4) % 2) : 1'b0);
        chk("ws", ws, en_b ? 1'((cyc / 256) % 2) : 1'b0);
        chk("level", fifo_level, mq.size());
        chk("valid", sample_valid, mq.size() > 0);
        chk("overrun", overrun, ovr);
        if (mq.size() > 0) chk("head", {sample_right, sample_data}, mq[0]);
        if (en1_b) c1++;
        chk("sck1", i2s_clk1, en1_b ? 1'(c1 % 2) : 1'b0);
        chk("ws1", ws1, en1_b ? 1'((c1 / 64) % 2) : 1'b0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int          n0, rise_at;
        logic        seen, ws1_p, sck1_p;
        logic [32:0] exp8 [8];
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_sck", i2s_clk, 1'b0);
        chk("rst_ws", ws, 1'b0);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_data", sample_data, 32'h0);
        chk("rst_right", sample_right, 1'b0);
        chk("rst_level", fifo_level, 4'd0);
        chk("rst_ovr", overrun, 1'b0);
        run(3);
        HRESETn = 1'b1;
        run(2);

        // CLK_DIV=1: SCK toggles every cycle, first WS rise 32 SCK periods in, WS moves only on a fall
        en1 = 1'b1;
        seen = 1'b0;
        rise_at = -1;
        for (int i = 0; i < 140; i++) begin
            ws1_p  = ws1;
            sck1_p = i2s_clk1;
            step();
            if (ws1 !== ws1_p) chk("ws1_on_fall", {sck1_p, i2s_clk1}, 2'b10);
            if (!seen && ws1) begin
                seen = 1'b1;
                rise_at = c1;
            end
        end
        chk("ws1_first_rise", rise_at, 64);
        en1 = 1'b0;
        run(2);

        // Basic frame
        fill();
        wq[0] = 32'hABCDEFAB;
        wq[1] = 32'h55667788;
        sample_ready = 1'b1;
        n0 = got.size();
        en = 1'b1;
        cyc = 0;
        run(520);
        chk("basic_count", got.size() - n0, 2);
        chk("basic_left", got[n0], {1'b0, 32'h00ABCDEF});
        chk("basic_right", got[n0 + 1], {1'b1, 32'h00556677});
        en = 1'b0;
        run(2);

        // Backpressure: 9 half-frames into an 8-deep FIFO
        fill();
        sample_ready = 1'b0;
        en = 1'b1;
        cyc = 0;
        run(2250);
        en = 1'b0;
        run(2);
        chk("bp_level", fifo_level, 4'd8);
        chk("bp_overrun", overrun, 1'b1);
        for (int i = 0; i < 8; i++) exp8[i] = {1'(i % 2), 8'h00, wq[i][31:8]};
        n0 = got.size();
        sample_ready = 1'b1;
        run(12);
        sample_ready = 1'b0;
        chk("bp_drained", got.size() - n0, 8);
        for (int i = 0; i < 8; i++) chk("bp_order", got[n0 + i], exp8[i]);
        overrun_clr = 1'b1;
        run(1);
        overrun_clr = 1'b0;
        chk("bp_clr", overrun, 1'b0);

        // Full FIFO with a pop on the exact push cycle
        fill();
        en = 1'b1;
        cyc = 0;
        run(2244);
        sample_ready = 1'b1;
        run(1);
        sample_ready = 1'b0;
        chk("fp_level", fifo_level, 4'd8);
        chk("fp_overrun", overrun, 1'b0);
        en = 1'b0;
        run(2);
        n0 = got.size();
        sample_ready = 1'b1;
        run(12);
        sample_ready = 1'b0;
        chk("fp_drained", got.size() - n0, 8);
        chk("fp_last", got[got.size() - 1], {1'b0, 8'h00, wq[8][31:8]});

        // Disable at left slot 10 with two entries queued
        fill();
        en = 1'b1;
        cyc = 0;
        run(600);
        en = 1'b0;
        run(1);
        chk("dis_sck", i2s_clk, 1'b0);
        chk("dis_ws", ws, 1'b0);
        run(300);
        chk("dis_level", fifo_level, 4'd2);
        sample_ready = 1'b1;
        run(4);
        chk("dis_drain", fifo_level, 4'd0);
        fill();
        wq[0] = 32'h12345678;
        en = 1'b1;
        cyc = 0;
        run(260);
        chk("reen_left", got[got.size() - 1], {1'b0, 32'h00123456});
        en = 1'b0;
        run(2);

        // Asynchronous reset with three entries queued and a sample mid-shift
        fill();
        sample_ready = 1'b0;
        en = 1'b1;
        cyc = 0;
        run(850);
        chk("pre_rst_level", fifo_level, 4'd3);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_sck", i2s_clk, 1'b0);
        chk("arst_ws", ws, 1'b0);
        chk("arst_valid", sample_valid, 1'b0);
        chk("arst_data", sample_data, 32'h0);
        chk("arst_right", sample_right, 1'b0);
        chk("arst_level", fifo_level, 4'd0);
        chk("arst_ovr", overrun, 1'b0);
        mq.delete();
        ovr = 1'b0;
        pend = 1'b0;
        en = 1'b0;
        run(2);
        HRESETn = 1'b1;
        fill();
        wq[0] = 32'h13579BDF;
        wq[1] = 32'h2468ACE0;
        sample_ready = 1'b1;
        n0 = got.size();
        en = 1'b1;
        cyc = 0;
        run(520);
        chk("post_rst_count", got.size() - n0, 2);
        chk("post_rst_left", got[n0], {1'b0, 32'h0013579B});
        chk("post_rst_right", got[n0 + 1], {1'b1, 32'h002468AC});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
